// File: rtl/golden_pkg.sv
// golden_pkg: shared mode encoding and checker counter width for the golden pattern source.
package golden_pkg;
  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_TRI, MODE_HOLD} mode_e;
  localparam int ERR_CNT_W = 16;
endpackage

// File: rtl/golden_hold_timer.sv
// golden_hold_timer: counts enabled cycles and fires a step once the count reaches hold_count.
module golden_hold_timer #(
  parameter int HOLD_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [HOLD_WIDTH-1:0] hold_count,
  output logic                  step
);
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
  // >= rather than == so that lowering hold_count below the count steps immediately
  always_comb begin
    step  = enable && !clear && (cnt_q >= hold_count);
    cnt_d = clear ? '0 : !enable ? cnt_q : step ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/golden_pattern_gen.sv
// golden_pattern_gen: multi-channel stepped up/down/triangle pattern source with phase-delayed copies.
// Define GOLDEN_CHECK_EN to add the channel-0 comparison checker with a saturating error counter.
module golden_pattern_gen
  import golden_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HOLD_WIDTH = 4,
  parameter int NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_Enable,
  input  logic                         i_Restart,
  input  logic [1:0]                   i_Mode,
  input  logic [HOLD_WIDTH-1:0]        i_Hold_Count,
  input  logic [DATA_WIDTH-1:0]        i_Wrap_Value,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_Output_Data,
  output logic                         o_Step,
  output logic                         o_Wrap
`ifdef GOLDEN_CHECK_EN
  ,
  input  logic                         i_Check_Valid,
  input  logic [DATA_WIDTH-1:0]        i_Check_Data,
  output logic                         o_Mismatch,
  output logic [ERR_CNT_W-1:0]         o_Error_Count
`endif
);
  mode_e mode;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_q, ch_d;
  logic [DATA_WIDTH-1:0] v, w;
  logic dir_q, dir_d, step_q, step_d, wrap_q, wrap_d, fire;
  assign mode = mode_e'(i_Mode);
  assign v    = ch_q[0];
  assign w    = i_Wrap_Value;
  golden_hold_timer #(.HOLD_WIDTH(HOLD_WIDTH)) u_timer (
    .clk(clk), .rst(rst), .enable(i_Enable), .clear(i_Restart),
    .hold_count(i_Hold_Count), .step(fire)
  );
  // dir_q: 0 = ascending, 1 = descending (only meaningful in triangle mode)
  always_comb begin
    ch_d   = ch_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (i_Restart) begin
      ch_d    = '0;
      ch_d[0] = (mode == MODE_DOWN) ? w : '0;
      dir_d   = 1'b0;
    end else if (i_Enable) begin
      if (fire) begin
        step_d = 1'b1;
        for (int k = 1; k < NUM_CH; k++) ch_d[k] = ch_q[k-1];
        if (mode == MODE_HOLD) ch_d[0] = v;
        else if (v > w) begin
          ch_d[0] = (mode == MODE_DOWN) ? w : '0;
          dir_d   = 1'b0;
          wrap_d  = 1'b1;
        end else if (mode == MODE_UP) begin
          ch_d[0] = (v == w) ? '0 : v + 1'b1;
          wrap_d  = (v == w);
        end else if (mode == MODE_DOWN) begin
          ch_d[0] = (v == '0) ? w : v - 1'b1;
          wrap_d  = (v == '0);
        end else if (!dir_q) begin
          ch_d[0] = (v == w) ? ((w == '0) ? '0 : w - 1'b1) : v + 1'b1;
          dir_d   = (v == w) && (w != '0);
          wrap_d  = (v == w) && (w == '0);
        end else begin
          ch_d[0] = (v == '0) ? ((w == '0) ? '0 : DATA_WIDTH'(1)) : v - 1'b1;
          dir_d   = (v != '0);
          wrap_d  = (v == '0);
        end
      end
      if (mode != MODE_TRI) dir_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch_q   <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  assign o_Output_Data = ch_q;
  assign o_Step        = step_q;
  assign o_Wrap        = wrap_q;
`ifdef GOLDEN_CHECK_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic mis_q, mis_d;
  always_comb begin
    mis_d = !i_Restart && i_Check_Valid && (i_Check_Data != v);
    err_d = i_Restart ? '0 : (mis_d && err_q != '1) ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_q <= '0;
      mis_q <= 1'b0;
    end else begin
      err_q <= err_d;
      mis_q <= mis_d;
    end
  assign o_Mismatch    = mis_q;
  assign o_Error_Count = err_q;
`endif
endmodule

// File: tb/tb_golden_pattern_gen.sv
// tb_golden_pattern_gen: directed self-checking bench for golden_pattern_gen (DATA_WIDTH=8, NUM_CH=2).
module tb_golden_pattern_gen;
  logic        clk, rst, en, restart;
  logic [1:0]  mode;
  logic [3:0]  hold;
  logic [7:0]  wrap;
  logic [15:0] data;
  logic        step, wrapo;
  int errors = 0;
  int checks = 0;
`ifdef GOLDEN_CHECK_EN
  logic        cvalid, mis;
  logic [7:0]  cdata;
  logic [15:0] ecnt;
`endif

  golden_pattern_gen #(.DATA_WIDTH(8), .HOLD_WIDTH(4), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .i_Enable(en), .i_Restart(restart), .i_Mode(mode),
    .i_Hold_Count(hold), .i_Wrap_Value(wrap), .o_Output_Data(data),
    .o_Step(step), .o_Wrap(wrapo)
`ifdef GOLDEN_CHECK_EN
    , .i_Check_Valid(cvalid), .i_Check_Data(cdata), .o_Mismatch(mis), .o_Error_Count(ecnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++;
    if (data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h exp 0000", data); end
    checks++;
    if ({step, wrapo} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b exp 00", {step, wrapo}); end
    rst = 1'b0;
  endtask

  task automatic test_up();
    logic [7:0] e0[5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    logic [7:0] e1[5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    logic       ew[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mode = 2'd0; hold = 4'd3; wrap = 8'd4; en = 1'b1;
    do_restart();
    for (int i = 0; i < 5; i++) begin
      repeat (3) cyc();
      checks++;
      if (step !== 1'b0) begin errors++; $display("FAIL up_idle %0d: step=%b exp 0", i, step); end
      cyc();
      checks++;
      if ({step, wrapo, data} !== {1'b1, ew[i], e1[i], e0[i]})
        begin errors++; $display("FAIL up_step %0d: step=%b wrap=%b ch1=%0d ch0=%0d exp 1 %b %0d %0d",
          i, step, wrapo, data[15:8], data[7:0], ew[i], e1[i], e0[i]); end
    end
  endtask

  task automatic test_down();
    logic [7:0] e0[5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic [7:0] e1[5] = '{8'd0, 8'd3, 8'd2, 8'd1, 8'd0};
    logic       ew[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    mode = 2'd0; hold = 4'd0; wrap = 8'd3;
    do_restart();
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({step, wrapo, data} !== {1'b1, ew[i], e1[i], e0[i]})
        begin errors++; $display("FAIL down_step %0d: step=%b wrap=%b ch1=%0d ch0=%0d exp 1 %b %0d %0d",
          i, step, wrapo, data[15:8], data[7:0], ew[i], e1[i], e0[i]); end
    end
  endtask

  task automatic test_triangle();
    logic [7:0] e0[8] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
    logic       ew[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'd2; hold = 4'd1; wrap = 8'd3;
    do_restart();
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (step !== 1'b0) begin errors++; $display("FAIL tri_idle %0d: step=%b exp 0", i, step); end
      cyc();
      checks++;
      if ({step, wrapo, data[7:0]} !== {1'b1, ew[i], e0[i]})
        begin errors++; $display("FAIL tri_step %0d: step=%b wrap=%b ch0=%0d exp 1 %b %0d",
          i, step, wrapo, data[7:0], ew[i], e0[i]); end
    end
    wrap = 8'd0; hold = 4'd0;
    do_restart();
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({step, wrapo, data[7:0]} !== {2'b11, 8'd0})
        begin errors++; $display("FAIL tri_w0 %0d: step=%b wrap=%b ch0=%0d exp 1 1 0", i, step, wrapo, data[7:0]); end
    end
  endtask

  task automatic test_out_of_range();
    mode = 2'd0; hold = 4'd0; wrap = 8'd8;
    do_restart();
    repeat (7) cyc();
    checks++;
    if (data[7:0] !== 8'd7) begin errors++; $display("FAIL oor_pre: ch0=%0d exp 7", data[7:0]); end
    wrap = 8'd5;
    cyc();
    checks++;
    if ({step, wrapo, data[7:0]} !== {2'b11, 8'd0})
      begin errors++; $display("FAIL oor_wrap: step=%b wrap=%b ch0=%0d exp 1 1 0", step, wrapo, data[7:0]); end
  endtask

  task automatic test_enable_freeze();
    int bad = 0;
    mode = 2'd0; hold = 4'd3; wrap = 8'd4;
    do_restart();
    repeat (2) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if ({step, wrapo, data} !== 18'h0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL freeze_hold: %0d frozen cycles changed, exp 0", bad); end
    en = 1'b1;
    cyc();
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL freeze_resume_idle: step=%b exp 0", step); end
    cyc();
    checks++;
    if ({step, data[7:0]} !== {1'b1, 8'd1})
      begin errors++; $display("FAIL freeze_resume_step: step=%b ch0=%0d exp 1 1", step, data[7:0]); end
  endtask

  task automatic test_restart_rst();
    int bad = 0;
    mode = 2'd0; hold = 4'd0; wrap = 8'd8;
    do_restart();
    repeat (3) cyc();
    checks++;
    if (data !== {8'd2, 8'd3}) begin errors++; $display("FAIL rs_pre: ch1=%0d ch0=%0d exp 2 3", data[15:8], data[7:0]); end
    mode = 2'd1;
    do_restart();
    checks++;
    if ({step, wrapo, data} !== {2'b00, 8'd0, 8'd8})
      begin errors++; $display("FAIL rs_down_restart: step=%b wrap=%b ch1=%0d ch0=%0d exp 0 0 0 8",
        step, wrapo, data[15:8], data[7:0]); end
    mode = 2'd0;
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({step, wrapo, data} !== 18'h0)
      begin errors++; $display("FAIL rs_async: step=%b wrap=%b data=%h exp 0 0 0000", step, wrapo, data); end
    cyc();
    hold = 4'd3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (step !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rs_release_idle: %0d early steps exp 0", bad); end
    cyc();
    checks++;
    if ({step, data[7:0]} !== {1'b1, 8'd1})
      begin errors++; $display("FAIL rs_release_step: step=%b ch0=%0d exp 1 1", step, data[7:0]); end
  endtask

`ifdef GOLDEN_CHECK_EN
  task automatic test_checker();
    int pulses = 0;
    mode = 2'd1; hold = 4'd0; wrap = 8'd9;
    do_restart();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cvalid = 1'b1;
      cdata  = (i == 2 || i == 5 || i == 8) ? 8'd1 : 8'd9;
      cyc();
      if (mis === 1'b1) pulses++;
    end
    cvalid = 1'b0;
    cyc();
    if (mis === 1'b1) pulses++;
    checks++;
    if (ecnt !== 16'd3) begin errors++; $display("FAIL chk_count: got %0d exp 3", ecnt); end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL chk_pulses: got %0d exp 3", pulses); end
    cvalid = 1'b1; cdata = 8'd200;
    repeat (70000) cyc();
    cvalid = 1'b0;
    checks++;
    if (ecnt !== 16'hFFFF) begin errors++; $display("FAIL chk_saturate: got %0d exp 65535", ecnt); end
    do_restart();
    checks++;
    if ({mis, ecnt} !== 17'h0) begin errors++; $display("FAIL chk_restart: mis=%b cnt=%0d exp 0 0", mis, ecnt); end
    en = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; restart = 1'b0; mode = 2'd0; hold = 4'd0; wrap = 8'd0;
`ifdef GOLDEN_CHECK_EN
    cvalid = 1'b0; cdata = 8'd0;
`endif
    test_reset();
    test_up();
    test_down();
    test_triangle();
    test_out_of_range();
    test_enable_freeze();
    test_restart_rst();
`ifdef GOLDEN_CHECK_EN
    test_checker();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/golden_pattern_gen.md
Name: golden_pattern_gen

Overview:
Parametrised multi-channel golden-pattern source for the adaptive clock management datapath. Generates a stepped counter pattern (up, down or triangle) between 0 and a run-time wrap value. Each step occurs after a programmable hold time. NUM_CH phase-delayed copies of the pattern are produced for downstream validation and comparison logic.

Parameters:
DATA_WIDTH, 8, width of each channel value and of i_Wrap_Value
HOLD_WIDTH, 4, width of hold-time counter and i_Hold_Count
NUM_CH, 2, number of output channels (>=1); channel k lags channel 0 by k steps

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
i_Enable  input  1  high: pattern advances; low: all state frozen
i_Restart  input  1  synchronous restart of pattern and history
i_Mode  input  2  0=UP, 1=DOWN, 2=TRIANGLE, 3=reserved (HOLD)
i_Hold_Count  input  HOLD_WIDTH  step period minus one, in cycles
i_Wrap_Value  input  DATA_WIDTH  maximum pattern value
o_Output_Data  output  NUM_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
o_Step  output  1  one-cycle pulse when the outputs update
o_Wrap  output  1  one-cycle pulse on pattern wrap/turnaround, coincident with o_Step

Behaviour:
- Reset: all channels 0, hold counter 0, direction up, o_Step=0, o_Wrap=0.
- Priority per cycle: rst > i_Restart > !i_Enable > normal operation.
- i_Restart: hold counter 0, direction up, all history channels 0, no pulses.
  - Channel 0 set to 0, except DOWN mode, where it is set to i_Wrap_Value.
- i_Enable low: no state change; o_Step and o_Wrap are 0.
- Hold timer: increments each enabled cycle.
  - When the counter is >= i_Hold_Count, a step fires and the counter clears.
  - Step period is i_Hold_Count+1 cycles; i_Hold_Count=0 steps every cycle.
  - Lowering i_Hold_Count below the current count steps on the next enabled cycle.
  - Inputs are sampled live.
- All outputs are registered. o_Step/o_Wrap are high in the same cycle the new values appear.
- Step, channel 0 new value v' from current v and W=i_Wrap_Value:
  - Out-of-range: if v > W, UP/TRIANGLE -> 0 with direction up; DOWN -> W. o_Wrap asserted in all three modes.
  - UP: v==W -> 0 with o_Wrap; else v+1.
  - DOWN: v==0 -> W with o_Wrap; else v-1.
  - TRIANGLE, direction up:
    - v==W -> W-1, direction down; W==0 -> stays 0 with o_Wrap.
    - otherwise v+1.
  - TRIANGLE, direction down: v==0 -> 1 (0 if W==0), direction up, o_Wrap; else v-1.
  - Triangle period is 2*W steps.
  - HOLD (mode 3): v unchanged; o_Step still pulses; no o_Wrap.
- Direction register is forced up in any cycle where i_Mode != TRIANGLE.
- Mode change takes effect at the next step, from the current v.
- History: on each step, channel k <= previous channel k-1 for k>=1. Channels update only on steps.
- Arithmetic is unsigned DATA_WIDTH and never overflows, because the wrap checks precede increment/decrement.
- Reset asserted mid-pattern clears everything immediately. The first step after release comes i_Hold_Count+1 enabled cycles later.

Optional Feature:
Macro GOLDEN_CHECK_EN.
- Defined: adds the following ports.
  - Inputs: i_Check_Valid (1), i_Check_Data (DATA_WIDTH).
  - Outputs: o_Mismatch (1), o_Error_Count (16).
- When i_Check_Valid is high, i_Check_Data is compared against the current registered channel 0.
- On mismatch:
  - o_Mismatch pulses the following cycle.
  - o_Error_Count increments, saturating at 16'hFFFF.
- rst and i_Restart clear the counter and pulse.
- Not defined: these ports and all checker logic are absent; core behaviour is identical.

Decomposition:
- Package golden_pkg:
  - enum mode_e (MODE_UP, MODE_DOWN, MODE_TRI, MODE_HOLD) on 2 bits.
  - ERR_CNT_W=16.
- Sub-module golden_hold_timer (HOLD_WIDTH): inputs clk, rst, enable, clear, hold_count; output step pulse.
- The history shift register and checker stay in the top module.

Test Plan:
- UP, Hold=3, Wrap=4, NUM_CH=2 -> ch0 steps 0,1,2,3,4,0 every 4 cycles; o_Wrap on 4->0; ch1 lags one step (0,0,1,2,3,4).
- DOWN, Hold=0, Wrap=3 -> ch0 0,3,2,1,0,3 every cycle; o_Wrap on 0->3 transitions.
- TRIANGLE, Hold=1, Wrap=3 -> 0,1,2,3,2,1,0,1 every 2 cycles; o_Wrap only on 0->1 after descent; Wrap=0 -> constant 0 with o_Wrap every step.
- Ch0 at 7 under UP, Wrap changed 8->5 -> next step yields 0 with o_Wrap. i_Enable low for 10 cycles -> outputs and timer frozen, no pulses.
- Assert i_Restart and rst mid-pattern (ch0=3, ch1=2) -> DOWN restart yields ch0=Wrap, ch1=0. rst async-clears all outputs to 0 without a clock edge.
- GOLDEN_CHECK_EN: feed i_Check_Data = ch0 except 3 corrupted samples -> o_Error_Count=3, 3 o_Mismatch pulses; force 70000 mismatches -> count saturates at 65535.
